scoreboard_7seg: RTL
====================

# scoreboard_7seg

Consumer end of the handball game's score outputs. It samples the 4-bit left and right scores, converts each to two decimal digits, and drives a 4-digit, common-anode, multiplexed seven-segment display. Once a player reaches the winning score, that player's digits flash. It sits beside `lamp_handball` at board top level, running on the display clock.

## Interface
- `REFRESH_DIV`, default 50000: clocks per digit slot (scan period = 4×REFRESH_DIV).
- `BLANK_CYC`, default 500: clocks at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
- `FLASH_DIV`, default 64: complete scans per flash half-period.
- `WIN_SCORE`, default 9: score at or above which a side is the winner (1..15).
- `clk_lf` input 1: display clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Score_Left` input 4: left score, binary, from the `clk_game` domain.
- `Score_Right` input 4: right score, binary, from the `clk_game` domain.
- `Seg` output 7: segments {g,f,e,d,c,b,a}, active low.
- `An` output 4: digit anodes, active low. An[3]=left tens, An[2]=left units, An[1]=right tens, An[0]=right units.
- `Dp` output 1: decimal point, active low.
- `Winner` output 2: [1]=left won, [0]=right won; sticky.

## Operation
- **Input capture.** Each score passes through 2 flops (s1, s2). The latched score is loaded from s2 only when s2 equals the previous s2 sample (stable for 2 consecutive clocks). This prevents multi-bit tearing.
- **Digit split.** tens = (s ≥ 10) ? 1 : 0; units = (s ≥ 10) ? s−10 : s. Values 0..15 map to 00..15.
- **Leading-zero blank.** A tens digit of 0 shows SEG_BLANK (7'h7F). A units digit is always shown, so 0 shows "0".
- **Scan FSM.** States DIG3 → DIG2 → DIG1 → DIG0 → DIG3, advancing when the slot counter reaches REFRESH_DIV−1.
  - The slot counter runs 0..REFRESH_DIV−1 and wraps at 0 on each transition.
  - While slot counter < BLANK_CYC: An=4'b1111 and Seg=SEG_BLANK.
  - Otherwise: only the current digit's anode is low, and Seg shows that digit's pattern.
- **Flash.**
  - The scan counter increments at each DIG0→DIG3 transition and wraps at FLASH_DIV−1.
  - `flash_on` toggles on each wrap. Its reset value is 1.
  - While `flash_on`=0, the digits of any side with its Winner bit set are blanked. The anode is still driven so that timing is unchanged.
- **Winner.**
  - Winner[1] sets when latched left ≥ WIN_SCORE. Winner[0] sets when latched right ≥ WIN_SCORE. Each side is independent, so both may be set.
  - Both bits clear only when both latched scores equal 0 (game reset) or on `rst`.
  - A set bit takes priority over a same-cycle clear.
- **Dp.** Low during the units slot of a side whose Winner bit is set, outside the blank window and regardless of flash. High otherwise.
- **Reset values.** An=4'b1111, Seg=7'h7F, Dp=1, Winner=2'b00, FSM=DIG3, all counters 0, flash_on=1, latched scores 0.

## Timing
- All outputs are registered. An, Seg and Dp update on the same edge.
- Input change → latched score: 3 clocks, provided the input is held stable.
- Latched score → Winner: 1 clock.
- Latched score → Seg: the first non-blank cycle of that digit's next slot.
- A slot boundary and a score latch in the same cycle: the new slot uses the new score.
- Mid-operation `rst` forces all reset values immediately (asynchronously). The scan restarts at DIG3 on the first edge after release.
- An input that toggles every clock is never latched. The previous value is held.

## Structure
- Package `scoreboard_pkg` holds:
  - SEG_BLANK and the 7-bit active-low digit patterns for 0..9;
  - the scan-state enum DIG3..DIG0;
  - the anode one-hot constants.
- Sub-module `seg7_decode`: combinational, 4-bit digit plus blank in → 7-bit Seg out. Instantiated once on the muxed digit.
- The top holds capture, split, FSM, counters, flash and the winner register.

## Test plan
Bench parameters: REFRESH_DIV=4, BLANK_CYC=1, FLASH_DIV=2, WIN_SCORE=9.

1. **Reset.** Assert `rst` mid-scan → An=1111, Seg=7F, Dp=1, Winner=00 in the same cycle. After release, the first slot is DIG3 blanked (left tens of 0).
2. **Score display.** Left=12, Right=3, held → within 3+16 clocks, An=0111 shows "1" (7'h79), An=1011 shows "2" (7'h24), An=1101 is blank, An=1110 shows "3" (7'h30). Every slot's first cycle has An=1111.
3. **Tearing filter.** Toggle Right between 5 and 10 every clock for 20 clocks → latched right never changes. Then hold 10 → latched 10 after 3 clocks, and the right digits show "10".
4. **Win and flash.** Left steps 8→9 → Winner=10 one clock after the latch. Left digits blank for 2 scans, show for 2 scans, and repeat. Dp is low in every left-units slot. Right digits are steady.
5. **Winner clear.** With Winner=10, set both scores to 0 → Winner=00 one clock after both latch, and flashing stops. Then set both to 9 in the same cycle → Winner=11.
6. **Boundary value.** Left=15 → "15" displayed (tens 7'h79, units 7'h12). A wrap to 0 displays blank tens and "0" units (7'h40).

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard display: segment patterns (active low,
// bit order {g,f,e,d,c,b,a}), scan-state encoding and anode one-hots.
package scoreboard_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG0 = 4'b1110;

    typedef enum logic [1:0] {
        DIG3 = 2'd0,
        DIG2 = 2'd1,
        DIG1 = 2'd2,
        DIG0 = 2'd3
    } scan_state_e;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] anode_of(input scan_state_e st);
        case (st)
            DIG3:    return AN_DIG3;
            DIG2:    return AN_DIG2;
            DIG1:    return AN_DIG1;
            default: return AN_DIG0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; blank_i forces all segments off.
module seg7_decode
    import scoreboard_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg_pattern(digit_i);

endmodule

// File: rtl/scoreboard_7seg.sv
// Score capture, winner tracking and multiplexed 4-digit seven-segment drive
// with per-slot blanking and winner flashing.
module scoreboard_7seg
    import scoreboard_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int FLASH_DIV   = 64,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk_lf,
    input  logic       rst,
    input  logic [3:0] Score_Left,
    input  logic [3:0] Score_Right,
    output logic [6:0] Seg,
    output logic [3:0] An,
    output logic       Dp,
    output logic [1:0] Winner
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [CW-1:0] RD_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
    localparam logic [FW-1:0] FL_LAST   = FW'(FLASH_DIV - 1);

    // Index 1 is the left side, index 0 the right side, matching Winner bits.
    logic [1:0][3:0] score_in, s1_q, s2_q, lat_q, lat_d;
    logic [1:0]      winner_q, winner_d;
    logic            both_zero;

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] scan_q, scan_d;
    logic          flash_q, flash_d;
    logic [3:0]    slot_val_q, slot_val_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       left_slot, units_slot, side_win, has_tens, in_blank, dec_blank;
    logic [3:0] digit;

    assign score_in  = {Score_Left, Score_Right};
    assign both_zero = (lat_q[1] == 4'd0) && (lat_q[0] == 4'd0);

    // A score is accepted only once two consecutive synchronised samples agree,
    // so a word caught mid-transition is never latched.
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        assign lat_d[gi]    = (s1_q[gi] == s2_q[gi]) ? s2_q[gi] : lat_q[gi];
        assign winner_d[gi] = (lat_q[gi] >= 4'(WIN_SCORE)) ? 1'b1 :
                              (both_zero ? 1'b0 : winner_q[gi]);
    end

    always_ff @(posedge clk_lf or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            lat_q      <= '0;
            winner_q   <= '0;
            state_q    <= DIG3;
            cnt_q      <= '0;
            scan_q     <= '0;
            flash_q    <= 1'b1;
            slot_val_q <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            s1_q       <= score_in;
            s2_q       <= s1_q;
            lat_q      <= lat_d;
            winner_q   <= winner_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            flash_q    <= flash_d;
            slot_val_q <= slot_val_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        scan_d  = scan_q;
        flash_d = flash_q;
        if (cnt_q == RD_LAST) begin
            cnt_d = '0;
            case (state_q)
                DIG3: state_d = DIG2;
                DIG2: state_d = DIG1;
                DIG1: state_d = DIG0;
                default: begin
                    state_d = DIG3;
                    if (scan_q == FL_LAST) begin
                        scan_d  = '0;
                        flash_d = ~flash_q;
                    end else begin
                        scan_d = scan_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs are built from next-state values so An/Seg/Dp line up with the
    // slot the counters are entering; the slot's score is frozen at its start.
    always_comb begin
        left_slot  = (state_d == DIG3) || (state_d == DIG2);
        units_slot = (state_d == DIG2) || (state_d == DIG0);
        side_win   = left_slot ? winner_d[1] : winner_d[0];
        slot_val_d = (cnt_d == '0) ? (left_slot ? lat_d[1] : lat_d[0]) : slot_val_q;
        has_tens   = (slot_val_d >= 4'd10);
        if (units_slot) begin
            digit = has_tens ? (slot_val_d - 4'd10) : slot_val_d;
        end else begin
            digit = {3'b000, has_tens};
        end
        in_blank  = (cnt_d < BLANK_LIM);
        dec_blank = in_blank || (!flash_d && side_win) || (!units_slot && !has_tens);
        an_d      = in_blank ? AN_OFF : anode_of(state_d);
        dp_d      = in_blank || !units_slot || !side_win;
    end

    seg7_decode u_decode (
        .digit_i (digit),
        .blank_i (dec_blank),
        .seg_o   (seg_d)
    );

    assign An     = an_q;
    assign Seg    = seg_q;
    assign Dp     = dp_q;
    assign Winner = winner_q;

endmodule
